pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_pkg.sv | 12 +
 rtl/pipe_hazard_ctrl_md_busy_tracker.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/pipe_hazard_pkg.sv
// Shared constants for the pipeline hazard controller.
// Holds the forwarding-select encodings and the legal mul/div latency range.
package pipe_hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam int MD_LATENCY_MIN = 1;
  localparam int MD_LATENCY_MAX = 15;

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_tracker.sv
// Mul/div occupancy tracker.
// An accepted issue loads MD_LATENCY; the counter then drains by one per
// cycle and holds at zero. Only reset cancels an operation in flight, so
// pipeline flushes never shorten the occupancy window.
module md_busy_tracker #(
  parameter int MD_LATENCY = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic issue,
  output logic busy
);

  localparam int CNT_W = $clog2(MD_LATENCY + 1);

  logic [CNT_W-1:0] occCnt;

  // Load on an accepted issue, otherwise drain toward zero without wrapping
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      occCnt <= '0;
    end else if (issue) begin
      occCnt <= CNT_W'(MD_LATENCY);
    end else if (occCnt != '0) begin
      occCnt <= occCnt - CNT_W'(1);
    end
  end

  assign busy = (occCnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding for decode and execute,
// load-use / branch / mul-div stall generation, and decode/execute flushes.
// Optional feature macro PIPE_HAZARD_STALL_CNT_EN adds a saturating 32-bit
// StallCount output counting cycles in which decode is stalled.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RsE,
  input  logic [REG_ADDR_W-1:0] RtE,
  input  logic [REG_ADDR_W-1:0] WriteRegE,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  input  logic [REG_ADDR_W-1:0] WriteRegW,
  input  logic                  BranchD,
  input  logic                  JumpD,
  input  logic                  PCSrcD,
  input  logic                  MdStartD,
  input  logic                  MdUseD,
  input  logic                  RegWriteE,
  input  logic                  MemtoRegE,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic                  RegWriteW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  ForwardAD,
  output logic                  ForwardBD,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  MdBusy
`ifdef PIPE_HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]           StallCount
`endif
);

  // MD_LATENCY is expected within MD_LATENCY_MIN..MD_LATENCY_MAX; the
  // tracker counter width follows from it.

  // Execute-stage source select: memory stage wins over writeback, and
  // register zero is never forwarded.
  function automatic logic [1:0] fwdSel(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  regWrM,
    input logic [REG_ADDR_W-1:0] wrM,
    input logic                  regWrW,
    input logic [REG_ADDR_W-1:0] wrW
  );
    if (regWrM && (wrM != '0) && (wrM == src)) begin
      return FWD_MEM;
    end else if (regWrW && (wrW != '0) && (wrW == src)) begin
      return FWD_WB;
    end
    return FWD_NONE;
  endfunction

  logic lwStall;
  logic brStall;
  logic mdStall;
  logic stallAny;
  logic exHitsD;
  logic memLoadHitsD;
  logic mdIssue;

  // Forwarding selects and hazard detection, all resolved in the current cycle
  always_comb begin
    ForwardAE    = fwdSel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    ForwardBE    = fwdSel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    ForwardAD    = RegWriteM && (RsD != '0) && (RsD == WriteRegM);
    ForwardBD    = RegWriteM && (RtD != '0) && (RtD == WriteRegM);

    lwStall      = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
    exHitsD      = RegWriteE && (WriteRegE != '0) &&
                   ((WriteRegE == RsD) || (WriteRegE == RtD));
    memLoadHitsD = MemtoRegM && (WriteRegM != '0) &&
                   ((WriteRegM == RsD) || (WriteRegM == RtD));
    brStall      = BranchD && (exHitsD || memLoadHitsD);
    mdStall      = (MdStartD || MdUseD) && MdBusy;
    stallAny     = lwStall || brStall || mdStall;

    StallF       = stallAny;
    StallD       = stallAny;
    FlushE       = stallAny;
    // A stalled decode keeps its instruction, so it must not be flushed
    FlushD       = (PCSrcD || JumpD) && !stallAny;
    // A mul/div is accepted only when decode actually advances
    mdIssue      = MdStartD && !stallAny;
  end

  md_busy_tracker #(
    .MD_LATENCY(MD_LATENCY)
  ) u_mdBusy (
    .CLK  (CLK),
    .RST  (RST),
    .issue(mdIssue),
    .busy (MdBusy)
  );

`ifdef PIPE_HAZARD_STALL_CNT_EN
  // Count stalled decode cycles, saturating at all-ones
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      StallCount <= '0;
    end else if (StallD && (StallCount != 32'hFFFF_FFFF)) begin
      StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule
